// File: rtl/cgra_host_sequencer_pkg.sv
// Shared types for the CGRA host bring-up sequencer.
package cgra_host_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDataLoad,
        StCfgStart,
        StWaitCfg,
        StRelease,
        StRun,
        StDone
    } state_e;

    // Loader register block byte offsets; the STATE_* entries are reserved for a later
    // state save/restore extension and are not driven yet.
    typedef enum logic [4:0] {
        LdStart          = 5'd0,
        LdRelease        = 5'd4,
        LdStateCmd       = 5'd8,
        LdStateReadAddr  = 5'd12,
        LdStateWriteAddr = 5'd16
    } loader_reg_e;

endpackage

// File: rtl/cgra_host_sequencer_if.sv
// Single-beat DTL write channel (command + write data) seen from the initiator side.
interface cgra_host_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  command_valid;
    logic                  write_valid;
    logic                  command_accept;
    logic                  write_accept;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output command_valid, write_valid, address, write_data,
        input  command_accept, write_accept
    );

    modport slave (
        input  command_valid, write_valid, address, write_data,
        output command_accept, write_accept
    );
endinterface

// File: rtl/cgra_host_sequencer_dtl_single_write.sv
// Issues one DTL write per iGo and reports when both command and data were accepted.
module dtl_single_write #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iGo,
    input  logic [ADDR_WIDTH-1:0] iAddr,
    input  logic [DATA_WIDTH-1:0] iData,
    output logic                  oComplete,
    cgra_host_sequencer_if.master bus
);
    logic                  cmd_valid_q;
    logic                  wr_valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Complete in the cycle the last outstanding accept arrives, so the caller can issue
    // the next write on the same edge.
    always_comb begin
        oComplete = (cmd_valid_q | wr_valid_q)
                  & (~cmd_valid_q | bus.command_accept)
                  & (~wr_valid_q | bus.write_accept);
    end

    // Valid/address/data registers; each valid drops independently on its own accept.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            cmd_valid_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else if (iGo) begin
            cmd_valid_q <= 1'b1;
            wr_valid_q  <= 1'b1;
            addr_q      <= iAddr;
            data_q      <= iData;
        end else begin
            if (bus.command_accept) cmd_valid_q <= 1'b0;
            if (bus.write_accept)   wr_valid_q  <= 1'b0;
        end
    end

    assign bus.command_valid = cmd_valid_q;
    assign bus.write_valid   = wr_valid_q;
    assign bus.address       = addr_q;
    assign bus.write_data    = data_q;
endmodule

// File: rtl/cgra_host_sequencer.sv
// Host bring-up controller: DMEM preload, loader start/release, then timed run.
module cgra_host_sequencer
    import cgra_host_seq_pkg::*;
#(
    parameter int unsigned INTERFACE_WIDTH      = 32,
    parameter int unsigned INTERFACE_ADDR_WIDTH = 32,
    parameter int unsigned GM_MEM_ADDR_WIDTH    = 13,
    parameter logic [INTERFACE_ADDR_WIDTH-1:0] LOADER_OFFSET = 'hC0000,
    parameter bit          PRELOAD              = 1'b1,
    parameter int unsigned CYCLE_LIMIT          = 5000000
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         iStart,
    output logic                         oBusy,
    output logic                         oDone,
    output logic                         oTimeout,
    output logic [31:0]                  oCycleCount,
    output logic [GM_MEM_ADDR_WIDTH-1:0] oSrcAddr,
    input  logic [INTERFACE_WIDTH-1:0]   iSrcData,
    input  logic                         iConfigDone,
    input  logic                         iHalted,
    cgra_host_sequencer_if.master        dmem,
    cgra_host_sequencer_if.master        loader
);
    state_e                           state_q, state_d;
    logic [GM_MEM_ADDR_WIDTH-1:0]     idx_q, idx_d;
    logic [31:0]                      count_q, count_d, count_inc;
    logic                             timeout_q, timeout_d;
    logic                             dmem_go, loader_go;
    logic                             dmem_done, loader_done;
    logic [INTERFACE_ADDR_WIDTH-1:0]  loader_addr;
    logic [INTERFACE_ADDR_WIDTH-1:0]  dmem_addr;

    assign count_inc = (count_q == '1) ? count_q : count_q + 32'd1;

    // Next-state, write issue and counter control.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        timeout_d   = timeout_q;
        dmem_go     = 1'b0;
        loader_go   = 1'b0;
        loader_addr = LOADER_OFFSET + INTERFACE_ADDR_WIDTH'(LdStart);
        case (state_q)
            StIdle, StDone: begin
                if (iStart) begin
                    timeout_d = 1'b0;
                    if (PRELOAD) begin
                        state_d = StDataLoad;
                        idx_d   = '0;
                        dmem_go = 1'b1;
                    end else begin
                        state_d   = StCfgStart;
                        loader_go = 1'b1;
                    end
                end
            end
            StDataLoad: begin
                if (dmem_done) begin
                    if (idx_q == '1) begin
                        state_d   = StCfgStart;
                        loader_go = 1'b1;
                    end else begin
                        idx_d   = idx_q + GM_MEM_ADDR_WIDTH'(1);
                        dmem_go = 1'b1;
                    end
                end
            end
            StCfgStart: begin
                if (loader_done) state_d = StWaitCfg;
            end
            StWaitCfg: begin
                if (iConfigDone) begin
                    state_d     = StRelease;
                    loader_go   = 1'b1;
                    loader_addr = LOADER_OFFSET + INTERFACE_ADDR_WIDTH'(LdRelease);
                end
            end
            StRelease: begin
                if (loader_done) begin
                    state_d = StRun;
                    count_d = '0;
                end
            end
            StRun: begin
                count_d = count_inc;
                // Halt takes priority over a timeout landing on the same edge.
                if (iHalted) begin
                    state_d   = StDone;
                    timeout_d = 1'b0;
                end else if (count_inc >= CYCLE_LIMIT) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Source address leads to the word being issued so its data is latched on the issue edge.
    always_comb begin
        oSrcAddr  = dmem_go ? idx_d : idx_q;
        dmem_addr = INTERFACE_ADDR_WIDTH'(oSrcAddr);
    end

    // State, word index, run counter and timeout flag.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign oBusy       = (state_q != StIdle) && (state_q != StDone);
    assign oDone       = (state_q == StDone);
    assign oTimeout    = timeout_q;
    assign oCycleCount = count_q;

    dtl_single_write #(
        .ADDR_WIDTH (INTERFACE_ADDR_WIDTH),
        .DATA_WIDTH (INTERFACE_WIDTH)
    ) u_dmem_write (
        .iClk      (iClk),
        .iReset    (iReset),
        .iGo       (dmem_go),
        .iAddr     (dmem_addr),
        .iData     (iSrcData),
        .oComplete (dmem_done),
        .bus       (dmem)
    );

    dtl_single_write #(
        .ADDR_WIDTH (INTERFACE_ADDR_WIDTH),
        .DATA_WIDTH (INTERFACE_WIDTH)
    ) u_loader_write (
        .iClk      (iClk),
        .iReset    (iReset),
        .iGo       (loader_go),
        .iAddr     (loader_addr),
        .iData     ('0),
        .oComplete (loader_done),
        .bus       (loader)
    );
endmodule
